// File: rtl/axil_arbiter_rr_wr.sv
// Round-robin write-channel arbiter placed in front of one AXI-Lite slave port.
// It grants one requesting master at a time and holds that grant from the
// grant cycle through the B handshake. While the grant is held, aw_open and
// w_open let exactly one AW beat and one W beat through to the slave.
module axil_arbiter_rr_wr #(
  parameter int NUMBER_MASTER = 4,
  parameter int IDX_WIDTH     = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUMBER_MASTER-1:0] request_wr,
  output logic [NUMBER_MASTER-1:0] grant_wr,
  output logic [IDX_WIDTH-1:0]     grant_idx,
  output logic                     grant_valid,
  input  logic                     s_axil_awvalid,
  input  logic                     s_axil_awready,
  input  logic                     s_axil_wvalid,
  input  logic                     s_axil_wready,
  input  logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  output logic                     aw_open,
  output logic                     w_open
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ADDR_DATA = 2'd1;
  localparam logic [1:0] ST_RESP      = 2'd2;

  logic [1:0]           state;
  logic                 aw_done;
  logic                 w_done;
  logic [IDX_WIDTH-1:0] ptr;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 pick_found;
  int                   cand;

  logic aw_hs;
  logic w_hs;
  logic b_hs;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign b_hs  = s_axil_bvalid & s_axil_bready;

  // The open signals are decoded from registered state only. Each one drops
  // the cycle after its own handshake, so no duplicate beat can reach the slave.
  assign aw_open = (state == ST_ADDR_DATA) & grant_valid & ~aw_done;
  assign w_open  = (state == ST_ADDR_DATA) & grant_valid & ~w_done;

  // Search for the first requester starting at ptr and wrapping around.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUMBER_MASTER; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUMBER_MASTER) cand = cand - NUMBER_MASTER;
      if (!pick_found && request_wr[cand[IDX_WIDTH-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_WIDTH'(cand);
      end
    end
  end

  // Transaction FSM: grant, then collect AW and W in either order, then wait for B and rotate ptr.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= ST_IDLE;
      grant_wr    <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      ptr         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_wr    <= NUMBER_MASTER'(1) << pick_idx;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            state       <= ST_ADDR_DATA;
          end
        end
        ST_ADDR_DATA: begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (b_hs) begin
            state       <= ST_IDLE;
            grant_wr    <= '0;
            grant_valid <= 1'b0;
            if (grant_idx == IDX_WIDTH'(NUMBER_MASTER - 1)) begin
              ptr <= '0;
            end else begin
              ptr <= grant_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axil_arbiter_rr_wr.md
Name: axil_arbiter_rr_wr

Overview:
- Per-slave write-channel arbiter for the priority-free variant of the AXI-Lite interconnect.
- One instance sits in front of each slave port, including the invalid-address sink.
- Takes the per-master request vector produced by the address decoders and grants exactly one master, round-robin.
- Holds the grant over the full AW/W/B transaction and gates the AW and W valids so each handshake is issued exactly once.

Parameters:
- NUMBER_MASTER, 4, number of requesting masters; must be >= 1.
- IDX_WIDTH, (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1, width of the grant index.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- areset  input  1  reset, asynchronous and active-high.
- request_wr  input  NUMBER_MASTER  bit i set: master i targets this slave; held until master i's B handshake completes.
- grant_wr  output  NUMBER_MASTER  one-hot grant; all zero when idle; drives the crossbar mux select.
- grant_idx  output  IDX_WIDTH  binary index of the granted master; valid while grant_valid=1.
- grant_valid  output  1  high while a grant is held.
- s_axil_awvalid  input  1  gated AW valid as presented to the slave.
- s_axil_awready  input  1  AW ready from the slave.
- s_axil_wvalid  input  1  gated W valid as presented to the slave.
- s_axil_wready  input  1  W ready from the slave.
- s_axil_bvalid  input  1  B valid from the slave.
- s_axil_bready  input  1  B ready from the granted master, routed through the crossbar.
- aw_open  output  1  AW pass-enable; the crossbar ANDs it into awvalid toward the slave and awready toward the master.
- w_open  output  1  W pass-enable; same use on the W channel.

Behaviour:
- Reset (areset=1, asynchronous): state=IDLE, grant_wr=0, grant_idx=0, grant_valid=0, aw_open=0, w_open=0, aw_done=0, w_done=0, rr pointer ptr=0.
- Reset mid-transaction discards the grant immediately; no response tracking survives reset.
- FSM states: IDLE, ADDR_DATA, RESP. All outputs are registered or decoded from registered state; there is no combinational path from request_wr to grant_wr.
- IDLE:
  - If request_wr != 0, select the first set bit searching from index ptr upward, wrapping modulo NUMBER_MASTER.
  - On the next edge: load grant_wr/grant_idx, set grant_valid=1, clear aw_done/w_done, go to ADDR_DATA.
  - Latency: request seen in cycle N gives grant in cycle N+1.
- ADDR_DATA:
  - aw_open = grant_valid & ~aw_done; w_open = grant_valid & ~w_done.
  - aw_done sets on s_axil_awvalid & s_axil_awready; w_done sets on s_axil_wvalid & s_axil_wready.
  - AW and W complete in any order, or in the same cycle.
  - When both are done (counting the current cycle's handshakes), go to RESP on the next edge.
  - aw_open and w_open drop the cycle after their own handshake, so no duplicate beat can pass.
- RESP:
  - aw_open=0, w_open=0.
  - On s_axil_bvalid & s_axil_bready: go to IDLE on the next edge, clear grant_wr and grant_valid, set ptr = (grant_idx + 1) mod NUMBER_MASTER.
  - grant_idx retains its last value.
- Handshakes outside their state are ignored: a B handshake in ADDR_DATA, and AW/W handshakes in IDLE or RESP. Stray valids with no grant cannot reach the slave because the open signals are low.
- The grant is stable from grant to B handshake; deasserting request_wr[g] while granted does not drop the grant.
- Minimum turnaround is one IDLE cycle between transactions. Back-to-back requesters are served with one bubble cycle.
- Fairness: with all masters requesting continuously, grants cycle 0,1,...,NUMBER_MASTER-1,0. No master waits more than NUMBER_MASTER-1 transactions.
- NUMBER_MASTER=1: ptr stays 0, grant_idx=0, grant_wr=1 whenever a grant is held.
- grant_wr is always zero or one-hot; grant_valid == |grant_wr.

Test Plan:
- Reset, then request_wr=4'b0100 in cycle 5 -> grant_wr=4'b0100, grant_idx=2, aw_open=w_open=1 in cycle 6. AW and W handshakes in cycle 8 -> aw_open=w_open=0 in cycle 9, state RESP. B handshake in cycle 11 -> grant_wr=0 in cycle 12, ptr=3.
- request_wr=4'b1111 held; the slave completes each transaction -> grant order 0,1,2,3,0. Each grant follows the prior B handshake by exactly 2 cycles (one IDLE bubble).
- W handshake in cycle 7 and AW in cycle 10 -> w_open low from cycle 8 with aw_open still high. RESP entered in cycle 11. A B handshake injected in cycle 9 is ignored.
- request_wr[g] dropped mid-ADDR_DATA -> grant_wr unchanged until the B handshake. request_wr=0 with stray s_axil_awvalid=1 in IDLE -> aw_open=0, no state change.
- areset pulsed asynchronously during RESP -> grant_wr=0, aw_open=w_open=0 before the next edge. Afterwards request_wr=4'b1010 -> grant master 1 (ptr=0).
- NUMBER_MASTER=1: two consecutive transactions -> grant_wr=1'b1 each time, grant_idx=0, one IDLE cycle between them.
